// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer pipeline stage with registered ready/valid on both sides.
// Optional bubble statistics counter enabled by defining PIPE_STAGE_BUF_STAT_EN.
//
// state | meaning
// EMPTY | no entry held, dn_data shows NOP_VAL
// ONE   | main holds the entry offered downstream
// FULL  | main and skid both hold entries, upstream stalled
module pipe_stage_buf #(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CNT_W-1:0]  stat_bubbles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] skid_reg;
  logic              up_ready_reg;
  logic              dn_valid_reg;

  // Handshake outputs are registered alongside the state, so up_ready never sees dn_ready.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state        <= EMPTY;
      main_reg     <= NOP_VAL;
      skid_reg     <= NOP_VAL;
      up_ready_reg <= 1'b1;
      dn_valid_reg <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (up_valid) begin
            main_reg     <= up_data;
            state        <= ONE;
            dn_valid_reg <= 1'b1;
          end
        end
        ONE: begin
          if (up_valid && dn_ready) begin
            main_reg <= up_data;
          end else if (up_valid) begin
            skid_reg     <= up_data;
            state        <= FULL;
            up_ready_reg <= 1'b0;
          end else if (dn_ready) begin
            main_reg     <= NOP_VAL;
            state        <= EMPTY;
            dn_valid_reg <= 1'b0;
          end
        end
        FULL: begin
          if (dn_ready) begin
            main_reg     <= skid_reg;
            skid_reg     <= NOP_VAL;
            state        <= ONE;
            up_ready_reg <= 1'b1;
          end
        end
        default: begin
          state        <= EMPTY;
          main_reg     <= NOP_VAL;
          skid_reg     <= NOP_VAL;
          up_ready_reg <= 1'b1;
          dn_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign up_ready = up_ready_reg;
  assign dn_valid = dn_valid_reg;
  assign dn_data  = dn_valid_reg ? main_reg : NOP_VAL;

`ifdef PIPE_STAGE_BUF_STAT_EN
  logic [CNT_W-1:0] bubbles;

  // Survives flush on purpose; only rst clears the statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbles <= '0;
    end else if (dn_ready && !dn_valid_reg && (bubbles != '1)) begin
      bubbles <= bubbles + 1'b1;
    end
  end

  assign stat_bubbles = bubbles;
`else
  assign stat_bubbles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: driver queues accepted payloads, monitor checks
// order, occupancy-derived handshakes and the bubble counter against a queue model.
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              up_valid;
  logic              up_ready;
  logic [DATA_W-1:0] up_data;
  logic              dn_valid;
  logic              dn_ready;
  logic [DATA_W-1:0] dn_data;
  logic [CNT_W-1:0]  stat_bubbles;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] sb_q[$];
  int                bub_model = 0;

  pipe_stage_buf #(
    .DATA_W (DATA_W),
    .NOP_VAL('0),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .up_data     (up_data),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready),
    .dn_data     (dn_data),
    .stat_bubbles(stat_bubbles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; accepted payloads go to the scoreboard.
  task automatic step(input logic uv, input logic [DATA_W-1:0] d, input logic dr,
                      input logic fl, input logic rs);
    rst      = rs;
    flush    = fl;
    up_valid = uv;
    up_data  = d;
    dn_ready = dr;
    if (!rs && !fl && uv && up_ready) sb_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: occupancy of the model is the number of accepted-but-undelivered entries.
  always @(negedge clk) begin
    int occ;
    int pend;
    logic [DATA_W-1:0] exp_d;
    if (rst) begin
      sb_q.delete();
      bub_model = 0;
    end else begin
      pend = (up_valid && up_ready && !flush) ? 1 : 0;
      occ  = sb_q.size() - pend;
      chk("dn_valid", 64'(dn_valid), 64'(occ > 0));
      chk("up_ready", 64'(up_ready), 64'(occ < 2));
      if (occ == 0) chk("dn_data_empty", 64'(dn_data), 64'(0));
`ifdef PIPE_STAGE_BUF_STAT_EN
      chk("stat_bubbles", 64'(stat_bubbles), 64'(bub_model));
      if (dn_ready && occ == 0 && bub_model < (1 << CNT_W) - 1) bub_model++;
`else
      chk("stat_bubbles", 64'(stat_bubbles), 64'(0));
`endif
      if (flush) begin
        sb_q.delete();
      end else if (dn_valid && dn_ready) begin
        if (occ > 0) begin
          exp_d = sb_q.pop_front();
          chk("dn_data", 64'(dn_data), 64'(exp_d));
        end else begin
          chk("dn_underflow", 64'(1), 64'(0));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Back-to-back stream with downstream always ready.
    step(1, 32'h11, 1, 0, 0);
    step(1, 32'h22, 1, 0, 0);
    step(1, 32'h33, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Fill to FULL, hold, then drain two.
    step(1, 32'hA1, 0, 0, 0);
    step(1, 32'hA2, 0, 0, 0);
    step(1, 32'hA3, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Flush from FULL with an upstream offer in the same cycle.
    step(1, 32'hB1, 0, 0, 0);
    step(1, 32'hB2, 0, 0, 0);
    step(1, 32'hB3, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("after_flush_valid", 64'(dn_valid), 64'(0));
    chk("after_flush_data", 64'(dn_data), 64'(0));
    step(0, 0, 1, 0, 0);

    // Idle with downstream ready: bubble counter saturates.
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
`ifdef PIPE_STAGE_BUF_STAT_EN
    chk("stat_saturated", 64'(stat_bubbles), 64'(15));
`else
    chk("stat_tied_zero", 64'(stat_bubbles), 64'(0));
`endif

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, $urandom,
           ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
           ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (legal range 1..256).
REQ-002 Parameter NOP_VAL, default 0 (DATA_W bits), bubble value driven and stored when empty or flushed.
REQ-003 Parameter CNT_W, default 16, width of the bubble statistics counter.
REQ-004 Port clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset: synchronous, active-high.
REQ-006 Port flush  input  1  discard all held entries.
REQ-007 Port up_valid  input  1  upstream offers up_data.
REQ-008 Port up_ready  output  1  stage accepts an upstream entry this cycle.
REQ-009 Port up_data  input  DATA_W  upstream payload.
REQ-010 Port dn_valid  output  1  dn_data holds a valid entry.
REQ-011 Port dn_ready  input  1  downstream accepts the entry this cycle.
REQ-012 Port dn_data  output  DATA_W  downstream payload.
REQ-013 Port stat_bubbles  output  CNT_W  count of downstream bubble cycles.

Function
REQ-014 A transfer occurs on a rising edge where valid and ready are both 1 on the same side; no other condition moves data.
REQ-015 The block SHALL hold two registers: main (drives dn_data) and skid, controlled by a state machine with states EMPTY, ONE and FULL.
REQ-016 dn_valid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-017 up_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it depends only on state, with no combinational path from dn_ready.
REQ-018 dn_data SHALL equal main in ONE and FULL and NOP_VAL in EMPTY.
REQ-019 EMPTY: up_valid=1 -> main<=up_data, go to ONE; otherwise stay in EMPTY.
REQ-020 ONE: up_valid=1 and dn_ready=1 -> main<=up_data, stay in ONE.
REQ-021 ONE: up_valid=1 and dn_ready=0 -> skid<=up_data, go to FULL; main unchanged.
REQ-022 ONE: up_valid=0 and dn_ready=1 -> main<=NOP_VAL, go to EMPTY.
REQ-023 ONE: up_valid=0 and dn_ready=0 -> hold.
REQ-024 FULL: dn_ready=1 -> main<=skid, skid<=NOP_VAL, go to ONE; otherwise hold. up_data is ignored.
REQ-025 Latency: an entry accepted at edge N SHALL appear on dn_data with dn_valid=1 after edge N, at the earliest.
REQ-026 Throughput: with dn_ready held at 1, the block SHALL sustain one transfer per cycle with no bubbles.
REQ-027 Ordering: entries SHALL leave in acceptance order; none are lost or duplicated.
REQ-028 flush=1 SHALL set state to EMPTY and main and skid to NOP_VAL; an upstream or downstream handshake in the same cycle is discarded.
REQ-029 flush takes priority over all handshake rules; rst takes priority over flush.
REQ-030 stat_bubbles SHALL increment on each edge where dn_ready=1 and dn_valid=0; it saturates at all-ones and is not cleared by flush.

Reset
REQ-031 On a rst edge the block SHALL enter EMPTY and set main=NOP_VAL, skid=NOP_VAL and stat_bubbles=0.
REQ-032 After reset, outputs SHALL be dn_valid=0, up_ready=1 and dn_data=NOP_VAL.
REQ-033 Reset in the middle of operation SHALL drop all held entries, with no partial transfer.

Configuration
REQ-034 The macro PIPE_STAGE_BUF_STAT_EN controls the bubble counter: when defined, the counter behaves as in REQ-030.
REQ-035 When PIPE_STAGE_BUF_STAT_EN is undefined, the counter SHALL NOT be built, stat_bubbles SHALL be tied to 0, and all other behaviour is identical.

Verification
REQ-036 Scenario: rst=1 for 2 cycles -> dn_valid=0, up_ready=1, dn_data=0, stat_bubbles=0.
REQ-037 Scenario: dn_ready=1, values 0x11, 0x22, 0x33 sent on consecutive cycles -> same values on dn_data on consecutive cycles, 1 cycle later, no gaps.
REQ-038 Scenario: 0xA1 accepted, then 0xA2 offered with dn_ready=0 -> FULL, up_ready=0; dn_ready=1 for 2 cycles -> 0xA1 then 0xA2 out, up_ready back to 1.
REQ-039 Scenario: FULL with 0xB1/0xB2, flush=1 while up_valid=1 with 0xB3 -> next cycle EMPTY, dn_valid=0, dn_data=0, 0xB3 never appears.
REQ-040 Scenario: with STAT_EN defined, CNT_W=4, dn_ready=1 and no input for 20 cycles -> stat_bubbles=15 (saturated); without the macro, stat_bubbles=0.
